// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg
// Shared definitions for the 3x3 matrix multiplier:
//   N, W          - matrix dimension and element width
//   IDX_W         - width of a bit offset into a flat N*N*W matrix bus
//   state_t       - controller states
//   elem_offset() - bit offset of element (row, col) in a row-major bus
package matrix_mult_pkg;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int IDX_W = $clog2(N * N * W);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    // Element (row, col) occupies bits [offset +: W] of a flat matrix bus.
    function automatic logic [IDX_W-1:0] elem_offset(input logic [1:0] row,
                                                     input logic [1:0] col);
        return IDX_W'((int'(row) * N + int'(col)) * W);
    endfunction

endpackage

// File: rtl/matrix_mult_mac.sv
// mm_mac
// Combinational multiply-accumulate step shared by every element product.
// Ports:
//   acc_in  - running partial sum
//   a, b    - unsigned operand elements
//   acc_out - acc_in + a*b, wrapped to W bits
module mm_mac #(
    parameter int W = 8
) (
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_out
);

    logic [2*W-1:0] product;

    // Only the low W bits of the product can influence a mod-2^W sum.
    always_comb begin
        product = a * b;
        acc_out = acc_in + product[W-1:0];
    end

endmodule

// File: rtl/matrix_mult.sv
// matrix_mult
// Sequential 3x3 unsigned matrix multiplier, C = A x B mod 2^W per element,
// iterating one shared MAC over all 27 element products.
// Ports:
//   Clock  - rising-edge clock
//   reset  - synchronous, active-low reset
//   Enable - level request: start (from IDLE) or hold a computation
//   A, B   - row-major operand matrices, element (i,j) at [(i*N+j)*W +: W]
//   C      - registered row-major result, updated only on completion
//   done   - high while the finished result is presented
module matrix_mult
    import matrix_mult_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             Enable,
    input  logic [N*N*W-1:0] A,
    input  logic [N*N*W-1:0] B,
    output logic [N*N*W-1:0] C,
    output logic             done
);

    localparam logic [1:0] LAST = 2'(N - 1);

    state_t           state;
    state_t           next_state;
    logic [N*N*W-1:0] a_reg;
    logic [N*N*W-1:0] b_reg;
    logic [N*N*W-1:0] res_reg;
    logic [N*N*W-1:0] res_next;
    logic [W-1:0]     acc;
    logic [W-1:0]     a_elem;
    logic [W-1:0]     b_elem;
    logic [W-1:0]     mac_out;
    logic [1:0]       i;
    logic [1:0]       j;
    logic [1:0]       k;
    logic             last_step;

    mm_mac #(.W(W)) u_mac (
        .acc_in  (acc),
        .a       (a_elem),
        .b       (b_elem),
        .acc_out (mac_out)
    );

    // Operand selection for the current (i,j,k) step, and the result array
    // as it will look once this step's finished element is written. C loads
    // from res_next so the final element lands in C on the same edge.
    always_comb begin
        a_elem    = a_reg[elem_offset(i, k) +: W];
        b_elem    = b_reg[elem_offset(k, j) +: W];
        last_step = (i == LAST) && (j == LAST) && (k == LAST);
        res_next  = res_reg;
        if (state == COMPUTE && k == LAST) begin
            res_next[elem_offset(i, j) +: W] = mac_out;
        end
    end

    // Next-state and output decode. Dropping Enable in COMPUTE aborts,
    // taking priority over completion.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (Enable) next_state = COMPUTE;
            end
            COMPUTE: begin
                if (!Enable)        next_state = IDLE;
                else if (last_step) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!Enable) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus datapath: operand capture on start, then k as the
    // inner loop, j, then i. The accumulator restarts after each element.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state   <= IDLE;
            C       <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        a_reg <= A;
                        b_reg <= B;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                COMPUTE: begin
                    if (Enable) begin
                        res_reg <= res_next;
                        if (k == LAST) begin
                            acc <= '0;
                            k   <= '0;
                            if (j == LAST) begin
                                j <= '0;
                                i <= (i == LAST) ? 2'd0 : i + 2'd1;
                            end else begin
                                j <= j + 2'd1;
                            end
                            if (last_step) C <= res_next;
                        end else begin
                            acc <= mac_out;
                            k   <= k + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult.sv
// tb_matrix_mult
// Directed-vector bench for matrix_mult. Each started computation pushes its
// hand-computed result onto a queue; an independent monitor pops and compares
// it against C whenever done rises.
module tb_matrix_mult;

    logic        Clock = 1'b0;
    logic        reset;
    logic        Enable;
    logic [71:0] A;
    logic [71:0] B;
    logic [71:0] C;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_q[$];
    logic        done_prev = 1'b0;

    matrix_mult #(.N(3), .W(8)) dut (
        .Clock  (Clock),
        .reset  (reset),
        .Enable (Enable),
        .A      (A),
        .B      (B),
        .C      (C),
        .done   (done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [71:0] pack9(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5,
                                          input int e6, input int e7, input int e8);
        int          e[9];
        logic [71:0] p;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        p = '0;
        for (int n = 0; n < 9; n++) p[n*8 +: 8] = 8'(e[n]);
        return p;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Start a computation, scramble the inputs right after capture, and wait
    // (bounded) for done; the result itself is checked by the monitor.
    task automatic applyStimulus(input string name, input logic [71:0] a_val,
                                 input logic [71:0] b_val, input logic [71:0] c_val);
        logic [95:0] junk;
        int          cyc;
        exp_q.push_back(c_val);
        A      = a_val;
        B      = b_val;
        Enable = 1'b1;
        tick();
        junk = {$urandom(), $urandom(), $urandom()};
        A    = junk[71:0];
        junk = {$urandom(), $urandom(), $urandom()};
        B    = junk[71:0];
        cyc  = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({name, "_latency"}, 72'(cyc), 72'd27);
    endtask

    // Hold Enable in DONE (no restart), then drop it and confirm release.
    task automatic holdAndRelease(input string name, input logic [71:0] c_val);
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput({name, "_hold_done"}, 72'(done), 72'd1);
        end
        checkOutput({name, "_hold_C"}, C, c_val);
        Enable = 1'b0;
        tick();
        checkOutput({name, "_release_done"}, 72'(done), 72'd0);
        checkOutput({name, "_release_C"}, C, c_val);
    endtask

    // Scoreboard monitor: every rising done must match the oldest expectation.
    initial begin
        logic [71:0] expected;
        forever begin
            @(negedge Clock);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 with C=%h, expected done=0", C);
                end else begin
                    expected = exp_q.pop_front();
                    checkOutput("result_C", C, expected);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [71:0] nom_a, nom_b, nom_c, id_a, wrap_ab, wrap_c;
        nom_a   = pack9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        nom_b   = pack9(2, 3, 4, 5, 6, 7, 8, 9, 1);
        nom_c   = pack9(36, 42, 21, 81, 96, 57, 126, 150, 93);
        id_a    = pack9(1, 0, 0, 0, 1, 0, 0, 0, 1);
        wrap_ab = pack9(255, 255, 255, 255, 255, 255, 255, 255, 255);
        wrap_c  = pack9(3, 3, 3, 3, 3, 3, 3, 3, 3);

        // Reset held with Enable asserted must win.
        reset  = 1'b0;
        Enable = 1'b1;
        A      = nom_a;
        B      = nom_b;
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("reset_C", C, 72'd0);
            checkOutput("reset_done", 72'(done), 72'd0);
        end
        reset  = 1'b1;
        Enable = 1'b0;
        tick();

        applyStimulus("nominal", nom_a, nom_b, nom_c);
        holdAndRelease("nominal", nom_c);

        applyStimulus("identity", id_a, nom_b, nom_b);
        holdAndRelease("identity", nom_b);

        applyStimulus("wrap", wrap_ab, wrap_ab, wrap_c);
        holdAndRelease("wrap", wrap_c);

        // Abort: Enable dropped before MAC cycle 10; C must keep the wrap result.
        A      = nom_a;
        B      = nom_b;
        Enable = 1'b1;
        tick();
        for (int n = 0; n < 9; n++) tick();
        Enable = 1'b0;
        tick();
        checkOutput("abort_done", 72'(done), 72'd0);
        checkOutput("abort_C", C, wrap_c);
        for (int n = 0; n < 30; n++) tick();
        checkOutput("abort_later_C", C, wrap_c);

        // A fresh start after the abort runs the full 27 cycles.
        applyStimulus("after_abort", nom_a, nom_b, nom_c);
        holdAndRelease("after_abort", nom_c);

        // Reset in the middle of a computation clears C and returns to IDLE.
        A      = id_a;
        B      = nom_b;
        Enable = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) tick();
        reset  = 1'b0;
        Enable = 1'b0;
        tick();
        checkOutput("midreset_C", C, 72'd0);
        checkOutput("midreset_done", 72'(done), 72'd0);
        reset = 1'b1;
        tick();

        applyStimulus("after_reset", id_a, nom_b, nom_b);
        holdAndRelease("after_reset", nom_b);

        tick();
        tick();
        checkOutput("scoreboard_drained", 72'(exp_q.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
